avalon_ram_responder: RTL and testbench



---
 rtl/avalon_ram_responder_if.sv | 21 ++
 rtl/avalon_ram_responder.sv | 97 +++++++++
 tb/tb_avalon_ram_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_ram_responder_if.sv
// Avalon-MM bus bundle between a CPU master and the RAM responder.
// The master holds a request until waitrequest is low, and then the transfer is complete.
interface avalon_ram_responder_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_ram_responder.sv
// Synthesizable Avalon-MM slave RAM with programmable wait states and a preload port.
// The memory array is not reset. Only the FSM, the counter and readdata are reset.
module avalon_ram_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_ram_responder_if.slave bus,
    input  logic                  inst_input,
    input  logic [ADDR_WIDTH+1:0] inst_addr,
    input  logic [31:0]           instruction,
    output logic [1:0]            state_dbg
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [31:0]             readdata_q;
    logic [31:0]             mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   bus_idx;
    logic [ADDR_WIDTH-1:0]   pre_idx;
    logic                    req;
    logic                    execute;
    logic                    do_write;
    logic [31:0]             merged;
    logic                    unused_bits;

    // The index silently wraps modulo the array depth.
    assign bus_idx     = bus.address[ADDR_WIDTH+1:2];
    assign pre_idx     = inst_addr[ADDR_WIDTH+1:2];
    assign unused_bits = ^{bus.address[31:ADDR_WIDTH+2], bus.address[1:0], inst_addr[1:0]};

    assign req      = bus.read | bus.write;
    assign execute  = (state == BUSY) && req && !inst_input && (cnt == 4'(WAIT_CYCLES));
    assign do_write = execute && bus.write;

    assign bus.waitrequest = req && (state != ACK);
    assign bus.readdata    = readdata_q;
    assign state_dbg       = state;

    always_comb begin
        merged = mem[bus_idx];
        for (int i = 0; i < 4; i++) begin
            if (bus.byteenable[i]) merged[8*i +: 8] = bus.writedata[8*i +: 8];
        end
    end

    // Preload and bus writes never coincide: preload holds the FSM out of BUSY.
    always_ff @(posedge clk) begin
        if (inst_input) begin
            mem[pre_idx] <= instruction;
        end else if (do_write) begin
            mem[bus_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            readdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !inst_input) begin
                        state <= BUSY;
                        cnt   <= 4'd0;
                    end
                end
                BUSY: begin
                    if (!req || inst_input) begin
                        state <= IDLE;
                    end else if (cnt == 4'(WAIT_CYCLES)) begin
                        state <= ACK;
                        // A simultaneous read and write performs the write and returns zero.
                        if (bus.write) begin
                            if (bus.read) readdata_q <= 32'd0;
                        end else begin
                            readdata_q <= mem[bus_idx];
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_ram_responder.sv
// Directed bench for avalon_ram_responder: preload, byte writes, wrap, latency, abort, reset.
module tb_avalon_ram_responder;
  localparam int AW = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic          clk;
  logic          reset;
  logic          inst_input;
  logic [AW+1:0] inst_addr;
  logic [31:0]   instruction;
  logic [1:0]    state_dbg;
  logic [1:0]    dbg_w0;
  logic [1:0]    dbg_w5;
  logic          sweep_read;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  avalon_ram_responder_if bus ();
  avalon_ram_responder_if bus_w0 ();
  avalon_ram_responder_if bus_w5 ();

  avalon_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .inst_input(inst_input), .inst_addr(inst_addr), .instruction(instruction),
    .state_dbg(state_dbg)
  );

  avalon_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset), .bus(bus_w0.slave),
    .inst_input(1'b0), .inst_addr('0), .instruction(32'd0),
    .state_dbg(dbg_w0)
  );

  avalon_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(5)) dut_w5 (
    .clk(clk), .reset(reset), .bus(bus_w5.slave),
    .inst_input(1'b0), .inst_addr('0), .instruction(32'd0),
    .state_dbg(dbg_w5)
  );

  assign bus_w0.read       = sweep_read;
  assign bus_w0.write      = 1'b0;
  assign bus_w0.address    = 32'h0;
  assign bus_w0.writedata  = 32'h0;
  assign bus_w0.byteenable = 4'hF;
  assign bus_w5.read       = sweep_read;
  assign bus_w5.write      = 1'b0;
  assign bus_w5.address    = 32'h0;
  assign bus_w5.writedata  = 32'h0;
  assign bus_w5.byteenable = 4'hF;

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus transfer on the WAIT_CYCLES=1 instance; ack_cycle is -1 if it never completes.
  task automatic bus_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int ack_cycle, output logic [31:0] rdata);
    ack_cycle = -1;
    rdata     = 32'd0;
    @(posedge clk); #1;
    bus.address    = addr;
    bus.writedata  = wdata;
    bus.byteenable = be;
    bus.read       = rd;
    bus.write      = wr;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.waitrequest) begin
        ack_cycle = c;
        rdata     = bus.readdata;
        break;
      end
      @(posedge clk);
    end
    @(posedge clk); #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] exp);
    int          ack;
    logic [31:0] rd;
    exp_q.push_back(exp);
    bus_op(1'b1, 1'b0, addr, 32'h0, be, ack, rd);
    check({tag, "_lat"}, 32'(ack), 32'd3);
    check({tag, "_data"}, rd, exp_q.pop_front());
  endtask

  task automatic bus_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    int          ack;
    logic [31:0] rd;
    bus_op(1'b0, 1'b1, addr, data, be, ack, rd);
    check({tag, "_lat"}, 32'(ack), 32'd3);
  endtask

  initial begin
    int          acks;
    int          ack;
    logic [31:0] rd;
    int          first0;
    int          second0;
    int          first5;

    reset          = 1'b0;
    inst_input     = 1'b0;
    inst_addr      = '0;
    instruction    = 32'd0;
    sweep_read     = 1'b0;
    bus.address    = 32'd0;
    bus.writedata  = 32'd0;
    bus.byteenable = 4'h0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_wait_noreq", 32'(bus.waitrequest), 32'd0);
    bus.read = 1'b1;
    #1;
    check("rst_wait_req", 32'(bus.waitrequest), 32'd1);
    bus.read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Preload two words while a bus read is held off
    @(posedge clk); #1;
    inst_input  = 1'b1;
    inst_addr   = 10'h004;
    instruction = 32'h2403F00F;
    bus.address = 32'h4;
    bus.read    = 1'b1;
    @(negedge clk);
    check("preload_wait", 32'(bus.waitrequest), 32'd1);
    check("preload_state", 32'(state_dbg), 32'(S_IDLE));
    @(posedge clk); #1;
    inst_addr   = 10'h014;
    instruction = 32'h00000008;
    @(negedge clk);
    check("preload_state2", 32'(state_dbg), 32'(S_IDLE));
    @(posedge clk); #1;
    inst_input = 1'b0;
    bus.read   = 1'b0;
    bus_read("preload_rd04", 32'h04, 4'hF, 32'h2403F00F);
    bus_read("preload_rd14", 32'h14, 4'hF, 32'h00000008);

    bus_write("bw_full", 32'h20, 32'hAABBCCDD, 4'hF);
    bus_write("bw_be5", 32'h20, 32'h11223344, 4'h5);
    bus_read("bw_rd", 32'h20, 4'hF, 32'hAA22CC44);
    bus_write("bw_be0", 32'h20, 32'h00000000, 4'h0);
    bus_read("bw_rd_be0", 32'h20, 4'h0, 32'hAA22CC44);

    bus_write("wrap_wr", 32'h400, 32'hDEADBEEF, 4'hF);
    bus_read("wrap_rd", 32'h000, 4'hF, 32'hDEADBEEF);

    bus_op(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, ack, rd);
    check("rw_lat", 32'(ack), 32'd3);
    check("rw_data", rd, 32'd0);
    bus_read("rw_mem", 32'h40, 4'hF, 32'hCAFEF00D);
    repeat (3) @(negedge clk);
    check("rd_hold", bus.readdata, 32'hCAFEF00D);

    // Abort: drop write while BUSY
    bus_write("ab_init", 32'h30, 32'h12345678, 4'hF);
    bus_read("ab_init_rd", 32'h30, 4'hF, 32'h12345678);
    @(posedge clk); #1;
    bus.address    = 32'h30;
    bus.writedata  = 32'hFFFFFFFF;
    bus.byteenable = 4'hF;
    bus.write      = 1'b1;
    @(posedge clk); #1;
    check("ab_busy", 32'(state_dbg), 32'(S_BUSY));
    bus.write = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (state_dbg == S_ACK) acks++;
    end
    check("ab_no_ack", 32'(acks), 32'd0);
    check("ab_idle", 32'(state_dbg), 32'(S_IDLE));
    check("ab_rd_hold", bus.readdata, 32'h12345678);
    bus_read("ab_rd", 32'h30, 4'hF, 32'h12345678);

    // Reset in the middle of a write to a preloaded word
    @(posedge clk); #1;
    bus.address    = 32'h14;
    bus.writedata  = 32'hFFFFFFFF;
    bus.byteenable = 4'hF;
    bus.write      = 1'b1;
    @(posedge clk); #1;
    check("mr_busy", 32'(state_dbg), 32'(S_BUSY));
    reset = 1'b0;
    #1;
    check("mr_state", 32'(state_dbg), 32'(S_IDLE));
    check("mr_readdata", bus.readdata, 32'd0);
    bus.write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus_read("mr_rd14", 32'h14, 4'hF, 32'h00000008);
    bus_read("mr_rd04", 32'h04, 4'hF, 32'h2403F00F);

    // Latency sweep on the WAIT_CYCLES=0 and 5 instances
    @(negedge clk);
    check("sw_w0_idle", 32'(dbg_w0), 32'(S_IDLE));
    check("sw_w5_idle", 32'(dbg_w5), 32'(S_IDLE));
    @(posedge clk); #1;
    sweep_read = 1'b1;
    first0  = -1;
    second0 = -1;
    first5  = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!bus_w0.waitrequest) begin
        if (first0 < 0) first0 = c;
        else if (second0 < 0) second0 = c;
      end
      if (!bus_w5.waitrequest && first5 < 0) first5 = c;
      @(posedge clk);
    end
    #1;
    sweep_read = 1'b0;
    check("sw_w0_ack", 32'(first0), 32'd2);
    check("sw_w0_b2b", 32'(second0), 32'd5);
    check("sw_w5_ack", 32'(first5), 32'd7);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
